// File: rtl/nibble_gen_pkg.sv
// nibble_gen_pkg
// Shared types and constants for the stepping nibble generator.
//   gen_state_t  : HOLD (manual stepping only) / RUN (prescaled auto-stepping)
//   NIBBLE_MAX/MIN : end points of the 4-bit value range
//   nibble_step  : one modulo-16 step in the requested direction
package nibble_gen_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

  localparam logic [3:0] NIBBLE_MAX = 4'hF;
  localparam logic [3:0] NIBBLE_MIN = 4'h0;

  function automatic logic [3:0] nibble_step(input logic [3:0] v, input logic up);
    return up ? (v + 4'd1) : (v - 4'd1);
  endfunction

endpackage

// File: rtl/nibble_step_gen_prescaler.sv
// tick_prescaler
// Divides clk down to a one-cycle tick every CLK_DIV cycles while run is high.
// The counter sits at zero whenever run is low, so the first tick after run
// rises arrives CLK_DIV cycles later. clear restarts the phase from zero.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   run   in  level; counting enabled
//   clear in  synchronous restart of the count (overrides a tick)
//   tick  out one-cycle pulse when the count reaches CLK_DIV-1
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // With CLK_DIV=1, LAST is 0 and the counter never leaves 0: tick every run cycle.
  assign tick = run & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nibble_step_gen.sv
// nibble_step_gen
// Internal 4-bit value source for the external/internal selector mux.
// The nibble free-runs at a prescaled rate (RUN), is single-stepped by a
// rising edge on stepReq (HOLD), or is parallel-loaded from loadVal.
// changed/wrap are registered one-cycle strobes aligned with the new value.
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   enable  in  level; 1 = RUN, 0 = HOLD
//   upDown  in  level; 1 = count up, 0 = count down
//   stepReq in  manual step request, rising edge detected here
//   loadReq in  level; load loadVal (highest priority after reset)
//   loadVal in  [3:0] parallel load data
//   value   out [3:0] current nibble
//   changed out one-cycle pulse: value was updated at the last edge
//   wrap    out one-cycle pulse: last update wrapped (or reversed)
// Build option:
//   NIBBLE_GEN_BOUNCE_EN defined: bounce between 0 and 15 instead of wrapping.
//   A direction flag follows upDown in HOLD and reverses at the end points in
//   RUN; wrap pulses on each reversal step.
module nibble_step_gen #(
  parameter int unsigned CLK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       upDown,
  input  logic       stepReq,
  input  logic       loadReq,
  input  logic [3:0] loadVal,
  output logic [3:0] value,
  output logic       changed,
  output logic       wrap
);

  import nibble_gen_pkg::*;

  gen_state_t state, state_d;

  logic       step_prev;
  logic       step_edge;
  logic       in_run;
  logic       tick;
  logic       clear;
  logic       advance;
  logic [3:0] value_d;
  logic       changed_d;
  logic       wrap_d;

`ifdef NIBBLE_GEN_BOUNCE_EN
  logic dir, dir_d;
  logic dir_eff;
`endif

  assign step_edge = stepReq & ~step_prev;
  assign in_run    = (state == RUN);

  // Leaving RUN or loading restarts the prescaler phase at the same edge.
  assign clear = in_run & (loadReq | ~enable);

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (in_run),
    .clear (clear),
    .tick  (tick)
  );

  // Auto ticks only in RUN; manual steps only in HOLD.
  assign advance = in_run ? tick : step_edge;

  always_comb begin
    state_d = state;
    case (state)
      HOLD: if (enable)  state_d = RUN;
      RUN:  if (!enable) state_d = HOLD;
    endcase
  end

`ifdef NIBBLE_GEN_BOUNCE_EN
  // HOLD steps follow upDown directly; RUN uses the latched flag.
  assign dir_eff = in_run ? dir : upDown;
`endif

  always_comb begin
    value_d   = value;
    changed_d = 1'b0;
    wrap_d    = 1'b0;
`ifdef NIBBLE_GEN_BOUNCE_EN
    dir_d     = dir_eff;
`endif
    if (loadReq) begin
      value_d   = loadVal;
      changed_d = (loadVal != value);
    end else if (advance) begin
      changed_d = 1'b1;
`ifdef NIBBLE_GEN_BOUNCE_EN
      if (dir_eff && (value == NIBBLE_MAX)) begin
        value_d = NIBBLE_MAX - 4'd1;
        wrap_d  = 1'b1;
        dir_d   = 1'b0;
      end else if (!dir_eff && (value == NIBBLE_MIN)) begin
        value_d = NIBBLE_MIN + 4'd1;
        wrap_d  = 1'b1;
        dir_d   = 1'b1;
      end else begin
        value_d = nibble_step(value, dir_eff);
      end
`else
      value_d = nibble_step(value, upDown);
      wrap_d  = upDown ? (value == NIBBLE_MAX) : (value == NIBBLE_MIN);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      step_prev <= 1'b0;
      value     <= '0;
      changed   <= 1'b0;
      wrap      <= 1'b0;
`ifdef NIBBLE_GEN_BOUNCE_EN
      dir       <= 1'b1;
`endif
    end else begin
      state     <= state_d;
      step_prev <= stepReq;
      value     <= value_d;
      changed   <= changed_d;
      wrap      <= wrap_d;
`ifdef NIBBLE_GEN_BOUNCE_EN
      dir       <= dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_step_gen.sv
module tb_nibble_step_gen;

  localparam int unsigned DIV = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       enable  = 1'b0;
  logic       upDown  = 1'b1;
  logic       stepReq = 1'b0;
  logic       loadReq = 1'b0;
  logic [3:0] loadVal = 4'd0;
  logic [3:0] value;
  logic       changed;
  logic       wrap;

  nibble_step_gen #(
    .CLK_DIV (DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .upDown  (upDown),
    .stepReq (stepReq),
    .loadReq (loadReq),
    .loadVal (loadVal),
    .value   (value),
    .changed (changed),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [3:0]  val;
    logic        wrp;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    checks++;
    fails++;
    $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected update visible `lat` cycles from now.
  task automatic push(input string n, input logic [3:0] v, input logic w, input int unsigned lat);
    sb.push_back('{n, v, w, cyc + lat});
  endtask

  // Monitor: every changed pulse must match the head of the scoreboard,
  // in value, wrap and arrival cycle; overdue entries are reported missing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (changed === 1'b1) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_change", int'(value), -1);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_value"}, 32'(value), 32'(mon_e.val));
          check({mon_e.name, "_wrap"}, 32'(wrap), 32'(mon_e.wrp));
          check({mon_e.name, "_cycle"}, cyc, mon_e.at);
        end
      end else begin
        if (wrap !== 1'b0) fail_now("wrap_without_change", 1, 0);
        if (sb.size() > 0 && cyc >= sb[0].at) begin
          mon_e = sb.pop_front();
          fail_now({mon_e.name, "_missing"}, int'(cyc), int'(mon_e.at));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, applied before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("reset_value", 32'(value), 0);
    check("reset_changed", 32'(changed), 0);
    check("reset_wrap", 32'(wrap), 0);
    cycles(2);
    rst_n = 1'b1;

    // HOLD: stepReq held high for 3 cycles steps exactly once.
    stepReq = 1'b1;
    push("hold_step", 4'd1, 1'b0, 1);
    cycles(3);
    stepReq = 1'b0;
    cycles(3);
    check("hold_step_settled", 32'(value), 1);

`ifdef NIBBLE_GEN_BOUNCE_EN
    // Bounce: 13 up -> 14, 15, 14 (reversal, wrap), 13; upDown ignored in RUN.
    loadReq = 1'b1; loadVal = 4'd13; upDown = 1'b1;
    push("load13", 4'd13, 1'b0, 1);
    cycles(1);
    loadReq = 1'b0;
    enable  = 1'b1;
    push("bounce_14", 4'd14, 1'b0, 1 + DIV);
    push("bounce_15", 4'd15, 1'b0, 1 + 2 * DIV);
    push("bounce_rev14", 4'd14, 1'b1, 1 + 3 * DIV);
    push("bounce_13", 4'd13, 1'b0, 1 + 4 * DIV);
    cycles(2);
    upDown = 1'b0;
    cycles(4 * DIV - 1);
    enable = 1'b0;
    upDown = 1'b1;
    cycles(4);
    check("bounce_settled", 32'(value), 13);
`else
    // RUN up from 14: 15 after DIV cycles, then 0 with wrap.
    loadReq = 1'b1; loadVal = 4'd14; upDown = 1'b1;
    push("load14", 4'd14, 1'b0, 1);
    cycles(1);
    loadReq = 1'b0;
    enable  = 1'b1;
    push("run_up15", 4'd15, 1'b0, 1 + DIV);
    push("run_wrap0", 4'd0, 1'b1, 1 + 2 * DIV);
    cycles(2 * DIV + 1);
    enable = 1'b0;
    cycles(4);
    check("run_wrap_settled", 32'(value), 0);

    // Loading the current value is not a change.
    loadReq = 1'b1; loadVal = 4'd0;
    cycles(1);
    loadReq = 1'b0;
    cycles(2);
    check("load_same_value", 32'(value), 0);

    // Down steps in HOLD: 0 -> 15 with wrap, then 15 -> 14 without.
    upDown  = 1'b0;
    stepReq = 1'b1;
    push("down_wrap15", 4'd15, 1'b1, 1);
    cycles(1);
    stepReq = 1'b0;
    cycles(1);
    stepReq = 1'b1;
    push("down_14", 4'd14, 1'b0, 1);
    cycles(1);
    stepReq = 1'b0;
    upDown  = 1'b1;
    cycles(2);
    check("down_settled", 32'(value), 14);
`endif

    // Load coinciding with a RUN tick wins; phase restarts from the load.
    loadReq = 1'b1; loadVal = 4'd5;
    push("load5", 4'd5, 1'b0, 1);
    cycles(1);
    loadReq = 1'b0;
    enable  = 1'b1;
    cycles(DIV);
    loadReq = 1'b1; loadVal = 4'd9;
    push("load_over_tick", 4'd9, 1'b0, 1);
    cycles(1);
    loadReq = 1'b0;
    push("tick_after_load", 4'd10, 1'b0, DIV);
    cycles(DIV);
    loadReq = 1'b1; loadVal = 4'd7;
    push("run_load7", 4'd7, 1'b0, 1);
    cycles(1);
    loadReq = 1'b0;
    cycles(2);
    check("pre_reset_value", 32'(value), 7);

    // Asynchronous reset mid-RUN, between clock edges.
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("async_reset_value", 32'(value), 0);
    check("async_reset_changed", 32'(changed), 0);
    check("async_reset_wrap", 32'(wrap), 0);
    #1 rst_n = 1'b1;
    cycles(6);
    check("post_reset_idle", 32'(value), 0);

    // Back in HOLD: manual step works, RUN tick needs a fresh enable.
    stepReq = 1'b1;
    push("post_reset_step", 4'd1, 1'b0, 1);
    cycles(1);
    stepReq = 1'b0;
    cycles(1);
    enable = 1'b1;
    push("post_reset_tick", 4'd2, 1'b0, 1 + DIV);
    cycles(1 + DIV);
    enable = 1'b0;
    cycles(4);
    check("final_value", 32'(value), 2);

    cycles(3);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/nibble_step_gen.md
Name: nibble_step_gen

Overview:
- Internal 4-bit value source feeding the "internal" data input of the external/internal 4-bit selector mux.
- Produces a stepping nibble: free-running at a prescaled rate, single-stepped by a manual pulse, or parallel-loaded.
- Also emits one-cycle change and wrap strobes for downstream display and LED logic.

Parameters:
- CLK_DIV, 100000000, clk cycles per automatic step in RUN; legal range 1..2^32-1.
- CNT_W, $clog2(CLK_DIV) with a minimum of 1, prescaler counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  level; 1 selects RUN, 0 selects HOLD.
- upDown  input  1  level; 1 counts up, 0 counts down.
- stepReq  input  1  manual step request; rising edge detected internally.
- loadReq  input  1  level; when 1, value takes loadVal.
- loadVal  input  4  parallel load data.
- value  output  4  current nibble; goes to the selector's internal input.
- changed  output  1  one-cycle pulse when value was updated at the last edge.
- wrap  output  1  one-cycle pulse when the last update wrapped (15->0 up, 0->15 down).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: value=0, changed=0, wrap=0, state=HOLD, prescaler=0, stepPrev=0.
- Input timing: all inputs are synchronous to clk. Debounce happens upstream.
- Edge detect: stepEdge = stepReq & ~stepPrev. stepPrev registers stepReq every cycle.
- FSM, two states:
  - HOLD: prescaler held at 0. If enable=1, go to RUN next cycle. A stepEdge in HOLD advances value by 1 in the upDown direction.
  - RUN: prescaler counts 0..CLK_DIV-1. When prescaler==CLK_DIV-1, tick=1, prescaler returns to 0, and value advances. If enable=0, go to HOLD and clear the prescaler at the same edge; a tick in that cycle is still applied. stepEdge is ignored in RUN.
- Update priority, highest first: reset > loadReq > advance (tick or stepEdge).
  - loadReq=1: value<=loadVal, changed<=1 only if loadVal!=value, wrap<=0.
  - In RUN, a load also clears the prescaler, and a coincident tick is discarded.
- Arithmetic: 4-bit modulo. Up: 15->0 with wrap=1. Down: 0->15 with wrap=1.
- Latency:
  - value updates at the edge ending the cycle in which the advance or load condition is true.
  - changed and wrap are registered and assert in the same cycle the new value is visible.
- Strobes: changed and wrap are single-cycle. With no update they return to 0.
- RUN timing: first tick occurs CLK_DIV cycles after entering RUN. CLK_DIV=1 gives a tick every RUN cycle.
- Direction change: an upDown change takes effect on the next advance. The prescaler phase is not disturbed.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Operation resumes in HOLD after rst_n deasserts.

Optional Feature:
- Macro: NIBBLE_GEN_BOUNCE_EN.
- Defined: no modular wrap. An internal direction flag, reset to up, is loaded from upDown whenever in HOLD.
  - In RUN it reverses at 15 (next step 14) and at 0 (next step 1).
  - wrap pulses on each reversal step.
  - In RUN, upDown is ignored.
- Undefined: modular wrap exactly as in Behaviour.

Decomposition:
- Package nibble_gen_pkg:
  - typedef enum logic {HOLD, RUN} gen_state_t.
  - localparam NIBBLE_MAX = 4'hF, NIBBLE_MIN = 4'h0.
- Sub-module tick_prescaler, parameterised by CLK_DIV:
  - inputs clk, rst_n, run, clear.
  - output tick, a one-cycle pulse.
- Top module holds the FSM, edge detect, value register and strobes.

Test Plan:
- Reset, then HOLD: stepReq 0->1 held 3 cycles -> value goes 0->1 exactly once; changed pulses for 1 cycle; wrap=0.
- CLK_DIV=4, enable=1, upDown=1 from value=14 -> value 15 after 4 RUN cycles, then 0 after 8. wrap=1 and changed=1 together on the 15->0 step only.
- upDown=0 at value=0 in HOLD, step -> value=15 and wrap=1.
- RUN with loadReq=1 and loadVal=9 coinciding with a tick -> value=9, no extra step. Next tick arrives 4 cycles later -> value=10.
- rst_n pulsed low asynchronously mid-RUN with value=7 -> value=0, changed=0, state HOLD without waiting for clk. No advance until enable is re-seen.
- NIBBLE_GEN_BOUNCE_EN defined, CLK_DIV=1, start 13 up -> sequence 14, 15, 14, 13. wrap pulses on the 15->14 step.
